// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int calc_clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int calc_half_bit(input int clock_freq, input int baud_rate);
        return calc_clks_per_bit(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to RESET_VAL.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output, frame-error and overrun pulses.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = calc_half_bit(CLOCK_FREQ, BAUD_RATE);
    localparam logic [15:0] FULL_TGT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_TGT = 16'(HALF_BIT - 1);

    logic        rx_s;
    logic        sample;
    uart_state_t state, state_next;
    logic [15:0] clk_count, clk_count_next;
    logic [2:0]  bit_index, bit_index_next;
    logic [7:0]  shift_reg, shift_next;
    logic        stop_err, stop_err_next;
    logic        deliver;
    logic        frame_err_next;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // rx_hist holds rx_s from one and two cycles back, so the vote spans target-2..target.
    logic [1:0] rx_hist;

    always_ff @(posedge clk) begin
        if (rst) rx_hist <= 2'b11;
        else     rx_hist <= {rx_hist[0], rx_s};
    end

    assign sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_s) | (rx_hist[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clk_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            stop_err  <= 1'b0;
        end else begin
            state     <= state_next;
            clk_count <= clk_count_next;
            bit_index <= bit_index_next;
            shift_reg <= shift_next;
            stop_err  <= stop_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        clk_count_next = clk_count;
        bit_index_next = bit_index;
        shift_next     = shift_reg;
        stop_err_next  = stop_err;
        deliver        = 1'b0;
        frame_err_next = 1'b0;
        unique case (state)
            IDLE: begin
                clk_count_next = '0;
                bit_index_next = '0;
                stop_err_next  = 1'b0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (clk_count == HALF_TGT) begin
                    clk_count_next = '0;
                    state_next     = sample ? IDLE : DATA;
                end else begin
                    clk_count_next = clk_count + 16'd1;
                end
            end
            DATA: begin
                if (clk_count == FULL_TGT) begin
                    clk_count_next        = '0;
                    shift_next[bit_index] = sample;
                    bit_index_next        = bit_index + 3'd1;
                    if (bit_index == 3'd7) state_next = STOP;
                end else begin
                    clk_count_next = clk_count + 16'd1;
                end
            end
            STOP: begin
                // After a bad stop bit, hold here until the line returns high.
                if (stop_err) begin
                    if (rx_s) begin
                        stop_err_next = 1'b0;
                        state_next    = IDLE;
                    end
                end else if (clk_count == FULL_TGT) begin
                    clk_count_next = '0;
                    if (sample) begin
                        deliver    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        stop_err_next  = 1'b1;
                    end
                end else begin
                    clk_count_next = clk_count + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A completed byte lands only if the output slot is empty or being drained this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_next;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_reg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serialised bytes are queued as expected and checked on handshake.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLOCK_FREQ = 6_400_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int BIT_CLKS   = CLOCK_FREQ / BAUD_RATE;
    localparam int MID        = BIT_CLKS / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] exp_q[$];
    int         frame_err_seen = 0;
    int         overrun_seen = 0;
    int         exp_frame_err = 0;
    int         exp_overrun = 0;

    uart_rx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL spurious_byte: got rx_data=%02h, required no byte", rx_data);
                end else begin
                    checkOutput("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err) frame_err_seen++;
            if (overrun)   overrun_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleLine(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            rx = 1'b1;
        end
    endtask

    task automatic driveBit(input logic v, input int n, input bit glitch);
        for (int c = 0; c < n; c++) begin
            tick();
            rx = (glitch && c == MID) ? ~v : v;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input int stop_bits, input bit glitch);
        driveBit(1'b0, BIT_CLKS, glitch);
        for (int i = 0; i < 8; i++) driveBit(data[i], BIT_CLKS, glitch);
        driveBit(stop_val, BIT_CLKS * stop_bits, glitch && stop_val);
    endtask

    task automatic waitDrain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 4 * BIT_CLKS) begin
            tick();
            budget++;
        end
        checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkCounts(input string name);
        checkOutput({name, "_frame_err_count"}, 32'(frame_err_seen), 32'(exp_frame_err));
        checkOutput({name, "_overrun_count"}, 32'(overrun_seen), 32'(exp_overrun));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         gap;

        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b1;
        repeat (5) tick();
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        idleLine(20);

        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1, 1, 1'b0);
        idleLine(BIT_CLKS);
        waitDrain("a5");
        checkOutput("a5_valid_cleared", 32'(rx_valid), 32'd0);
        checkCounts("a5");

        // Low glitch far shorter than half a bit must be rejected as a false start.
        for (int c = 0; c < 20; c++) begin
            tick();
            rx = 1'b0;
        end
        idleLine(3 * BIT_CLKS);
        checkOutput("glitch_state", 32'(dut.state), 32'(IDLE));
        checkOutput("glitch_valid", 32'(rx_valid), 32'd0);
        checkCounts("glitch");

        exp_frame_err++;
        applyStimulus(8'h3C, 1'b0, 2, 1'b0);
        idleLine(BIT_CLKS);
        checkOutput("ferr_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h81);
        applyStimulus(8'h81, 1'b1, 1, 1'b0);
        idleLine(BIT_CLKS);
        waitDrain("after_ferr");
        checkCounts("ferr");

        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        applyStimulus(8'h11, 1'b1, 1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1, 1'b0);
        exp_overrun++;
        idleLine(BIT_CLKS);
        checkOutput("ovr_valid_held", 32'(rx_valid), 32'd1);
        checkOutput("ovr_data_held", 32'(rx_data), 32'h11);
        checkCounts("ovr");
        rx_ready = 1'b1;
        idleLine(4);
        waitDrain("ovr");
        checkOutput("ovr_valid_cleared", 32'(rx_valid), 32'd0);

        fork
            applyStimulus(8'hFF, 1'b1, 1, 1'b0);
            begin
                repeat (4 * BIT_CLKS) tick();
                rst = 1'b1;
                repeat (3) tick();
                rst = 1'b0;
            end
        join
        checkOutput("midrst_valid", 32'(rx_valid), 32'd0);
        idleLine(BIT_CLKS);
        exp_q.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1, 1, 1'b0);
        idleLine(BIT_CLKS);
        waitDrain("midrst");
        checkCounts("midrst");

`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'h96);
        applyStimulus(8'h96, 1'b1, 1, 1'b1);
        idleLine(BIT_CLKS);
        waitDrain("majority");
        checkCounts("majority");
`endif

        for (int n = 0; n < 64; n++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                exp_frame_err++;
                applyStimulus(b, 1'b0, 1, 1'b0);
                gap = 4 + int'($urandom_range(0, BIT_CLKS));
            end else begin
                exp_q.push_back(b);
                applyStimulus(b, 1'b1, 1, 1'b0);
                gap = int'($urandom_range(0, BIT_CLKS));
            end
            idleLine(gap);
        end
        idleLine(BIT_CLKS);
        waitDrain("random");
        checkCounts("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer divide), HALF_BIT = CLKS_PER_BIT/2.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 SHALL have port rx_data  output  8  received byte, stable while rx_valid=1.
REQ-007 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid&&rx_ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because output was full.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; a 16-bit clk_count and a 3-bit bit_index SHALL track position.
REQ-013 IDLE: clk_count=0, bit_index=0; rx_s==0 SHALL move to START.
REQ-014 START: at clk_count==HALF_BIT-1, sampled bit 0 SHALL move to DATA with clk_count=0; sampled bit 1 (false start) SHALL return to IDLE without any output activity.
REQ-015 DATA: at clk_count==CLKS_PER_BIT-1 the sampled bit SHALL be shifted into shift_reg[bit_index] and clk_count cleared; after bit_index==7 SHALL move to STOP.
REQ-016 STOP: at clk_count==CLKS_PER_BIT-1, sampled 1 SHALL deliver shift_reg (REQ-018) and move to IDLE; sampled 0 SHALL pulse frame_err, discard the byte, and remain in STOP until rx_s==1, then IDLE.
REQ-017 Sampling points SHALL therefore land mid-bit; rx_valid SHALL rise the cycle after the mid-stop sample.
REQ-018 Delivery: if rx_valid==0 or (rx_valid&&rx_ready) in the same cycle, rx_data<=shift_reg and rx_valid<=1, overrun stays 0; otherwise overrun SHALL pulse, rx_data and rx_valid unchanged.
REQ-019 rx_valid SHALL clear on rx_valid&&rx_ready when no new byte delivers that cycle; rx_ready while rx_valid==0 SHALL have no effect.
REQ-020 Receiver SHALL accept a new start bit in the cycle after returning to IDLE (back-to-back frames, no idle gap required).

Reset
REQ-021 On rst: state=IDLE, clk_count=0, bit_index=0, shift_reg=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-022 rst mid-frame SHALL abandon the frame with no output; a frame already in progress when rst deasserts SHALL be received only from its next start edge.

Configuration
REQ-023 Macro UART_RX_MAJORITY_EN defined: each sample (start check, data, stop) SHALL be the 2-of-3 majority of rx_s at counts target-2, target-1, target, decided at target (target = HALF_BIT-1 or CLKS_PER_BIT-1).
REQ-024 Macro undefined: each sample SHALL be the single value of rx_s at target; no extra sample registers.

Structure
REQ-025 A shared package uart_pkg SHALL hold the state enum type (IDLE/START/DATA/STOP, 2 bits) and the CLKS_PER_BIT/HALF_BIT computation function, shared with the transmitter.
REQ-026 The synchronizer SHALL be a sub-module uart_rx_sync (2 flops, reset value parameterised, default 1).

Verification
REQ-027 Drive 0xA5 at 115200 baud, rx_ready=1 -> single rx_valid pulse with rx_data=0xA5, frame_err=0, overrun=0.
REQ-028 200 ns low glitch on idle line -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-029 Frame 0x3C with stop bit 0 held low 2 bit times -> frame_err single pulse, no rx_valid; following valid frame 0x81 -> rx_data=0x81.
REQ-030 Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_valid=1, rx_data=0x11, overrun pulse at second stop; then rx_ready=1 -> rx_valid clears.
REQ-031 rst asserted mid DATA of 0xFF, next frame 0x5A -> only 0x5A delivered.
REQ-032 With UART_RX_MAJORITY_EN: 1-cycle inverted glitch at each mid-bit of 0x96 -> rx_data=0x96; loopback from the transmitter, 256 random bytes -> all match in order.
